// File: rtl/reset_sequencer_pkg.sv
// ============================================================================
// Module   : reset_sequencer_pkg
// Purpose  : Sequencer state encodings (SEQ_WAIT_CLK/HOLD/RELEASE/RUN) and
//            the counter width helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    SEQ_WAIT_CLK = 2'd0,
    SEQ_HOLD     = 2'd1,
    SEQ_RELEASE  = 2'd2,
    SEQ_RUN      = 2'd3
  } seq_state_e;

  // Guards $clog2 against collapsing to zero bits for tiny values.
  function automatic int safe_clog2(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reset_sequencer_if.sv
// ============================================================================
// Module   : reset_sequencer_if
// Purpose  : Housekeeping-side control and status bundle of the sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface reset_sequencer_if #(
  parameter int N_STAGES = 3
);
  logic                clock_valid;
  logic                soft_reset_req;
  logic                wdt_enable;
  logic                wdt_kick;
  logic [N_STAGES-1:0] domain_resetb;
  logic                seq_done;
  logic [1:0]          seq_state;
  logic                wdt_fired;

  modport master (
    output clock_valid, soft_reset_req, wdt_enable, wdt_kick,
    input  domain_resetb, seq_done, seq_state, wdt_fired
  );

  modport slave (
    input  clock_valid, soft_reset_req, wdt_enable, wdt_kick,
    output domain_resetb, seq_done, seq_state, wdt_fired
  );
endinterface

`default_nettype wire

// File: rtl/reset_seq_sync.sv
// ============================================================================
// Module   : reset_seq_sync
// Purpose  : STAGES-deep synchronizer with asynchronous active-low clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reset_seq_sync #(
  parameter int STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_d,
  output logic      o_q
);

  logic [STAGES-1:0] r_sync;

  generate
    if (STAGES == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= 1'b0;
        else        r_sync <= i_d;
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '0;
        else        r_sync <= {r_sync[STAGES-2:0], i_d};
      end
    end
  endgenerate

  assign o_q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Ordered release of N_STAGES domain resets after POR and clock-valid,
//            with soft-reset and clock-loss re-sequencing. Optional watchdog
//            enabled by defining RESET_SEQ_WATCHDOG_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int N_STAGES    = 3,
  parameter int SYNC_STAGES = 2,
  parameter int STAGE_DELAY = 16,
  parameter int WDT_WIDTH   = 24
) (
  input  wire logic          clock,
  input  wire logic          resetb,
  reset_sequencer_if.slave   bus
);

  localparam int c_CNT_W = safe_clog2(STAGE_DELAY);
  localparam int c_IDX_W = safe_clog2(N_STAGES);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(STAGE_DELAY - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_STAGES - 1);

  logic w_rstn_int;
  logic w_cv_s;
  logic w_wdt_expire;

  seq_state_e          r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_IDX_W-1:0]  r_idx;
  logic [N_STAGES-1:0] r_dom;
  logic                r_done;
  logic                r_wdt_fired;

  reset_seq_sync #(.STAGES(SYNC_STAGES)) u_rst_sync (
    .clk   (clock),
    .rst_n (resetb),
    .i_d   (1'b1),
    .o_q   (w_rstn_int)
  );

  reset_seq_sync #(.STAGES(SYNC_STAGES)) u_cv_sync (
    .clk   (clock),
    .rst_n (w_rstn_int),
    .i_d   (bus.clock_valid),
    .o_q   (w_cv_s)
  );

`ifdef RESET_SEQ_WATCHDOG_EN
  logic [WDT_WIDTH-1:0] r_wdt_cnt;

  // A kick on the expiry cycle suppresses the fire.
  assign w_wdt_expire = (r_state == SEQ_RUN) && bus.wdt_enable &&
                        !bus.wdt_kick && (&r_wdt_cnt);

  always_ff @(posedge clock or negedge w_rstn_int) begin
    if (!w_rstn_int) begin
      r_wdt_cnt <= '0;
    end else if ((r_state != SEQ_RUN) || bus.wdt_kick || w_wdt_expire) begin
      r_wdt_cnt <= '0;
    end else if (bus.wdt_enable) begin
      r_wdt_cnt <= r_wdt_cnt + 1'b1;
    end
  end
`else
  logic w_unused_wdt;
  assign w_unused_wdt = bus.wdt_enable ^ bus.wdt_kick ^ WDT_WIDTH[0];
  assign w_wdt_expire = 1'b0;
`endif

  always_ff @(posedge clock or negedge w_rstn_int) begin
    if (!w_rstn_int) begin
      r_state     <= SEQ_WAIT_CLK;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_dom       <= '0;
      r_done      <= 1'b0;
      r_wdt_fired <= 1'b0;
    end else begin
      r_wdt_fired <= 1'b0;
      if ((r_state != SEQ_WAIT_CLK) && !w_cv_s) begin
        r_state <= SEQ_WAIT_CLK;
        r_cnt   <= '0;
        r_idx   <= '0;
        r_dom   <= '0;
        r_done  <= 1'b0;
      end else if ((r_state != SEQ_WAIT_CLK) && (w_wdt_expire || bus.soft_reset_req)) begin
        // Aborts take precedence over any release due on this edge.
        r_state     <= SEQ_HOLD;
        r_cnt       <= '0;
        r_idx       <= '0;
        r_dom       <= '0;
        r_done      <= 1'b0;
        r_wdt_fired <= w_wdt_expire;
      end else begin
        case (r_state)
          SEQ_WAIT_CLK: begin
            if (w_cv_s) begin
              r_state <= SEQ_HOLD;
              r_cnt   <= '0;
            end
          end
          SEQ_HOLD: begin
            if (r_cnt == c_CNT_MAX) begin
              r_dom[0] <= 1'b1;
              r_cnt    <= '0;
              if (N_STAGES == 1) begin
                r_state <= SEQ_RUN;
                r_done  <= 1'b1;
              end else begin
                r_idx   <= c_IDX_W'(1);
                r_state <= SEQ_RELEASE;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          SEQ_RELEASE: begin
            if (r_cnt == c_CNT_MAX) begin
              r_dom[r_idx] <= 1'b1;
              r_cnt        <= '0;
              if (r_idx == c_IDX_LAST) begin
                r_state <= SEQ_RUN;
                r_done  <= 1'b1;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.domain_resetb = r_dom;
  assign bus.seq_done      = r_done;
  assign bus.seq_state     = r_state;
  assign bus.wdt_fired     = r_wdt_fired;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// Module   : tb_reset_sequencer
// Purpose  : Directed self-checking bench for reset_sequencer (default params;
//            WDT_WIDTH=4 when RESET_SEQ_WATCHDOG_EN is defined).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam int c_WDT_W = 4;
`else
  localparam int c_WDT_W = 24;
`endif

  logic clk;
  logic resetb;
  int   checks;
  int   failures;

  reset_sequencer_if #(.N_STAGES(3)) bus ();

  reset_sequencer #(
    .N_STAGES    (3),
    .SYNC_STAGES (2),
    .STAGE_DELAY (16),
    .WDT_WIDTH   (c_WDT_W)
  ) dut (
    .clock  (clk),
    .resetb (resetb),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns at the falling edge following the n-th rising edge.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Pulses resetb; edge 1 is the first rising edge after it goes high.
  task automatic por_release();
    @(negedge clk);
    resetb = 1'b0;
    wait_edges(2);
    resetb = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetb = 1'b0;
    wait_edges(3);
    checks++;
    if ({bus.domain_resetb, bus.seq_done, bus.seq_state, bus.wdt_fired} !== 7'b000_0_00_0) begin
      failures++;
      $display("FAIL reset_state: got dom=%b done=%b state=%0d fired=%b required 000/0/0/0",
               bus.domain_resetb, bus.seq_done, bus.seq_state, bus.wdt_fired);
    end
  endtask

  task automatic test_power_up();
    logic [2:0] exp_dom;
    logic [1:0] exp_st;
    por_release();
    for (int e = 1; e <= 60; e++) begin
      wait_edges(1);
      exp_dom = {(e >= 53), (e >= 37), (e >= 21)};
      exp_st  = (e >= 53) ? 2'd3 : (e >= 21) ? 2'd2 : (e >= 5) ? 2'd1 : 2'd0;
      checks++;
      if (bus.domain_resetb !== exp_dom || bus.seq_state !== exp_st ||
          bus.seq_done !== (e >= 53)) begin
        failures++;
        $display("FAIL power_up edge %0d: got dom=%b state=%0d done=%b required dom=%b state=%0d done=%b",
                 e, bus.domain_resetb, bus.seq_state, bus.seq_done, exp_dom, exp_st, e >= 53);
      end
    end
  endtask

  task automatic test_async_reset();
    por_release();
    wait_edges(40);
    checks++;
    if (bus.domain_resetb !== 3'b011 || bus.seq_state !== 2'd2) begin
      failures++;
      $display("FAIL async_pre: got dom=%b state=%0d required 011/2", bus.domain_resetb, bus.seq_state);
    end
    #1 resetb = 1'b0;
    #1;
    checks++;
    if (bus.domain_resetb !== 3'b000 || bus.seq_state !== 2'd0 || bus.seq_done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got dom=%b state=%0d done=%b required 000/0/0",
               bus.domain_resetb, bus.seq_state, bus.seq_done);
    end
  endtask

  task automatic test_clock_loss();
    por_release();
    wait_edges(53);
    bus.clock_valid = 1'b0;
    wait_edges(3);
    checks++;
    if (bus.domain_resetb !== 3'b000 || bus.seq_state !== 2'd0 || bus.seq_done !== 1'b0) begin
      failures++;
      $display("FAIL clk_loss: got dom=%b state=%0d done=%b required 000/0/0",
               bus.domain_resetb, bus.seq_state, bus.seq_done);
    end
    wait_edges(2);
    bus.clock_valid = 1'b1;
    wait_edges(18);
    checks++;
    if (bus.domain_resetb !== 3'b000 || bus.seq_state !== 2'd1) begin
      failures++;
      $display("FAIL clk_return_early: got dom=%b state=%0d required 000/1", bus.domain_resetb, bus.seq_state);
    end
    wait_edges(1);
    checks++;
    if (bus.domain_resetb !== 3'b001 || bus.seq_state !== 2'd2) begin
      failures++;
      $display("FAIL clk_return_release: got dom=%b state=%0d required 001/2", bus.domain_resetb, bus.seq_state);
    end
  endtask

  task automatic test_soft_reset();
    por_release();
    wait_edges(53);
    bus.soft_reset_req = 1'b1;
    wait_edges(1);
    bus.soft_reset_req = 1'b0;
    checks++;
    if (bus.domain_resetb !== 3'b000 || bus.seq_state !== 2'd1 || bus.seq_done !== 1'b0) begin
      failures++;
      $display("FAIL soft_abort: got dom=%b state=%0d done=%b required 000/1/0",
               bus.domain_resetb, bus.seq_state, bus.seq_done);
    end
    wait_edges(15);
    checks++;
    if (bus.domain_resetb !== 3'b000) begin
      failures++;
      $display("FAIL soft_hold: got dom=%b required 000", bus.domain_resetb);
    end
    wait_edges(1);
    checks++;
    if (bus.domain_resetb !== 3'b001 || bus.seq_state !== 2'd2) begin
      failures++;
      $display("FAIL soft_rerelease: got dom=%b state=%0d required 001/2", bus.domain_resetb, bus.seq_state);
    end
  endtask

  task automatic test_soft_on_release_edge();
    por_release();
    wait_edges(36);
    checks++;
    if (bus.domain_resetb !== 3'b001) begin
      failures++;
      $display("FAIL edge36: got dom=%b required 001", bus.domain_resetb);
    end
    bus.soft_reset_req = 1'b1;
    wait_edges(1);
    bus.soft_reset_req = 1'b0;
    checks++;
    if (bus.domain_resetb !== 3'b000 || bus.seq_state !== 2'd1) begin
      failures++;
      $display("FAIL soft_wins_edge37: got dom=%b state=%0d required 000/1", bus.domain_resetb, bus.seq_state);
    end
    wait_edges(15);
    checks++;
    if (bus.domain_resetb !== 3'b000) begin
      failures++;
      $display("FAIL edge52: got dom=%b required 000", bus.domain_resetb);
    end
    wait_edges(1);
    checks++;
    if (bus.domain_resetb !== 3'b001) begin
      failures++;
      $display("FAIL edge53: got dom=%b required 001", bus.domain_resetb);
    end
  endtask

  task automatic test_soft_in_wait_clk();
    bus.clock_valid = 1'b0;
    por_release();
    wait_edges(6);
    bus.soft_reset_req = 1'b1;
    wait_edges(1);
    bus.soft_reset_req = 1'b0;
    wait_edges(1);
    checks++;
    if (bus.seq_state !== 2'd0 || bus.domain_resetb !== 3'b000) begin
      failures++;
      $display("FAIL soft_in_wait: got state=%0d dom=%b required 0/000", bus.seq_state, bus.domain_resetb);
    end
    bus.clock_valid = 1'b1;
  endtask

  task automatic test_watchdog();
    bus.wdt_enable = 1'b1;
    por_release();
    wait_edges(53);
`ifdef RESET_SEQ_WATCHDOG_EN
    for (int e = 1; e <= 17; e++) begin
      wait_edges(1);
      checks++;
      if (bus.wdt_fired !== (e == 16)) begin
        failures++;
        $display("FAIL wdt_fire edge %0d: got fired=%b required %b", e, bus.wdt_fired, e == 16);
      end
    end
    checks++;
    if (bus.seq_state !== 2'd1 || bus.domain_resetb !== 3'b000) begin
      failures++;
      $display("FAIL wdt_resequence: got state=%0d dom=%b required 1/000", bus.seq_state, bus.domain_resetb);
    end
    wait_edges(47);
    checks++;
    if (bus.seq_state !== 2'd3) begin
      failures++;
      $display("FAIL wdt_rerun: got state=%0d required 3", bus.seq_state);
    end
    for (int e = 1; e <= 40; e++) begin
      bus.wdt_kick = (e % 10 == 0);
      wait_edges(1);
      checks++;
      if (bus.wdt_fired !== 1'b0 || bus.seq_state !== 2'd3) begin
        failures++;
        $display("FAIL wdt_kicked edge %0d: got fired=%b state=%0d required 0/3", e, bus.wdt_fired, bus.seq_state);
      end
    end
    bus.wdt_kick = 1'b0;
`else
    for (int e = 1; e <= 40; e++) begin
      wait_edges(1);
      checks++;
      if (bus.wdt_fired !== 1'b0 || bus.seq_state !== 2'd3) begin
        failures++;
        $display("FAIL wdt_off edge %0d: got fired=%b state=%0d required 0/3", e, bus.wdt_fired, bus.seq_state);
      end
    end
`endif
    bus.wdt_enable = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetb             = 1'b0;
    bus.clock_valid    = 1'b1;
    bus.soft_reset_req = 1'b0;
    bus.wdt_enable     = 1'b0;
    bus.wdt_kick       = 1'b0;

    test_reset();
    test_power_up();
    test_async_reset();
    test_clock_loss();
    test_soft_reset();
    test_soft_on_release_edge();
    test_soft_in_wait_clk();
    test_watchdog();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
